// File: rtl/hardfloat_norm_pkg.sv
// Shared widths, constants and state encoding for the FMA add/sub normalization sequencer.
package hardfloat_norm_pkg;

  localparam int unsigned SIG_W  = 108;
  localparam int unsigned DIST_W = 8;
  localparam int unsigned REM_W  = 7;

  localparam logic [DIST_W-1:0] EST_BIAS  = 8'd53;
  localparam logic [DIST_W-1:0] EST_MAX   = 8'd160;
  localparam logic [DIST_W-1:0] ZERO_DIST = 8'd160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/norm_shift_step.sv
// Combinational left shifter: shifts a SIG_W-bit value by 0..SHIFT_STEP, zero fill.
module norm_shift_step
  import hardfloat_norm_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 16
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [REM_W-1:0] amt,
  output logic [SIG_W-1:0] sig_shifted_c
);

  localparam logic [REM_W-1:0] STEP_MAX = REM_W'(SHIFT_STEP);

  logic [REM_W-1:0] amt_lim;

  // Amount is bounded so the shifter never exceeds its per-cycle reach.
  always_comb begin
    amt_lim       = (amt > STEP_MAX) ? STEP_MAX : amt;
    sig_shifted_c = sig << amt_lim;
  end

endmodule

// File: rtl/norm_shift_sequencer.sv
// Multi-cycle normalization controller: shifts the sum by the anticipated distance, fixes a
// one-bit under-estimate, and hands off over valid/ready. NORM_SEQ_EST_CHECK_EN enables est_err.
module norm_shift_sequencer
  import hardfloat_norm_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIG_W-1:0]  in_sig,
  input  logic [DIST_W-1:0] in_est,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIG_W-1:0]  out_sig,
  output logic [DIST_W-1:0] out_dist,
  output logic              out_zero,
  output logic              est_err
);

  localparam logic [REM_W-1:0] STEP_MAX = REM_W'(SHIFT_STEP);

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d, shifted_c;
  logic [DIST_W-1:0] dist_q, dist_d, est_clamp_c;
  logic [REM_W-1:0]  rem_q, rem_d, rem_init_c, amt_c;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
`ifdef NORM_SEQ_EST_CHECK_EN
  logic              err_q, err_d;
`endif

  norm_shift_step #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_step (
    .sig          (sig_q),
    .amt          (amt_c),
    .sig_shifted_c(shifted_c)
  );

  // Clamp the estimate into the legal window and derive the shift still owed.
  always_comb begin
    if (in_est < EST_BIAS)     est_clamp_c = EST_BIAS;
    else if (in_est > EST_MAX) est_clamp_c = EST_MAX;
    else                       est_clamp_c = in_est;
    rem_init_c = REM_W'(est_clamp_c - EST_BIAS);
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    dist_d  = dist_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    ready_d = ready_q;
    amt_c   = '0;
`ifdef NORM_SEQ_EST_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sig_d   = in_sig;
          dist_d  = est_clamp_c;
          rem_d   = rem_init_c;
          zero_d  = 1'b0;
          ready_d = 1'b0;
`ifdef NORM_SEQ_EST_CHECK_EN
          err_d   = 1'b0;
`endif
          if (in_sig == '0) begin
            state_d = DONE;
            dist_d  = ZERO_DIST;
            zero_d  = 1'b1;
            valid_d = 1'b1;
          end else if (rem_init_c == '0) begin
            state_d = CHECK;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        amt_c = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;
        sig_d = shifted_c;
        rem_d = rem_q - amt_c;
        if (rem_d == '0) state_d = CHECK;
      end
      CHECK: begin
        state_d = DONE;
        valid_d = 1'b1;
        // Anticipator may be one short; a second miss means the estimate was bad.
        if (!sig_q[SIG_W-1]) begin
          amt_c  = REM_W'(1);
          sig_d  = shifted_c;
          dist_d = dist_q + DIST_W'(1);
`ifdef NORM_SEQ_EST_CHECK_EN
          err_d  = ~shifted_c[SIG_W-1];
`endif
        end
      end
      DONE: begin
        if (valid_q && out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sig_q   <= '0;
      dist_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef NORM_SEQ_EST_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      dist_q  <= dist_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
`ifdef NORM_SEQ_EST_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_sig   = sig_q;
  assign out_dist  = dist_q;
  assign out_zero  = zero_q;
`ifdef NORM_SEQ_EST_CHECK_EN
  assign est_err   = err_q;
`else
  assign est_err   = 1'b0;
`endif

endmodule

// File: tb/tb_norm_shift_sequencer.sv
// Self-checking bench for norm_shift_sequencer: directed cases, backpressure, mid-run reset,
// and randomized requests against a one-shot arithmetic reference model.
module tb_norm_shift_sequencer;

  localparam int unsigned STEP = 16;
  localparam int          TMO  = 300;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [107:0] in_sig;
  logic [7:0]   in_est;
  logic         out_valid;
  logic         out_ready;
  logic [107:0] out_sig;
  logic [7:0]   out_dist;
  logic         out_zero;
  logic         est_err;

  int n_vec  = 0;
  int n_fail = 0;

  norm_shift_sequencer #(.SHIFT_STEP(STEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sig   (in_sig),
    .in_est   (in_est),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sig  (out_sig),
    .out_dist (out_dist),
    .out_zero (out_zero),
    .est_err  (est_err)
  );

  always #5 clk = ~clk;

  // Reference: one full shift by the clamped distance, then the one-bit correction.
  function automatic void model(input logic [107:0] s, input logic [7:0] e,
                                output logic [107:0] xs, output logic [7:0] xd,
                                output logic xz, output logic xe, output int lat);
    int d, rem;
    d = int'(e);
    if (d < 53) d = 53;
    if (d > 160) d = 160;
    xz = 1'b0;
    xe = 1'b0;
    if (s == '0) begin
      xs = '0; xd = 8'd160; xz = 1'b1; lat = 1;
      return;
    end
    rem = d - 53;
    xs  = s << rem;
    if (!xs[107]) begin
      xs = xs << 1;
      d  = d + 1;
      xe = !xs[107];
    end
`ifndef NORM_SEQ_EST_CHECK_EN
    xe = 1'b0;
`endif
    xd  = 8'(d);
    lat = (rem == 0) ? 2 : 2 + (rem + int'(STEP) - 1) / int'(STEP);
  endfunction

  task automatic check_result(input string tag, input logic [107:0] xs, input logic [7:0] xd,
                              input logic xz, input logic xe);
    if (out_sig !== xs) begin
      n_fail++; $display("FAIL %s out_sig: got %h want %h", tag, out_sig, xs);
    end
    if (out_dist !== xd) begin
      n_fail++; $display("FAIL %s out_dist: got %0d want %0d", tag, out_dist, xd);
    end
    if (out_zero !== xz) begin
      n_fail++; $display("FAIL %s out_zero: got %b want %b", tag, out_zero, xz);
    end
    if (est_err !== xe) begin
      n_fail++; $display("FAIL %s est_err: got %b want %b", tag, est_err, xe);
    end
  endtask

  task automatic run_one(input string tag, input logic [107:0] s, input logic [7:0] e,
                         input int delay);
    logic [107:0] xs;
    logic [7:0]   xd;
    logic         xz, xe;
    int           lat, k;
    model(s, e, xs, xd, xz, xe, lat);
    n_vec++;
    @(negedge clk);
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; in_sig = s; in_est = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (out_valid !== 1'b1 && k < TMO) begin
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s in_ready_busy: got %b want 0", tag, in_ready);
      end
      @(posedge clk); #1; k++;
    end
    if (k != lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, k, lat);
    end
    check_result(tag, xs, xd, xz, xe);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s hold_valid: got v=%b r=%b want v=1 r=0", tag, out_valid, in_ready);
      end
      check_result(tag, xs, xd, xz, xe);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s handshake: got v=%b r=%b want v=0 r=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sig = '0; in_est = '0;
    repeat (3) @(posedge clk);
    #1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    if (out_sig !== '0 || out_dist !== 8'd0 || out_zero !== 1'b0 || est_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: got sig=%h dist=%0d z=%b e=%b want all 0",
                         out_sig, out_dist, out_zero, est_err);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [107:0] one = 108'd1;
    run_one("aligned",   one << 107, 8'd53,  0);
    run_one("two_shift", one << 87,  8'd73,  1);
    run_one("off_by_one", one << 86, 8'd73,  0);
    run_one("zero",      '0,         8'd160, 2);
    run_one("est_bad",   one << 85,  8'd73,  0);
    run_one("clamp_lo",  one << 107, 8'd10,  0);
    run_one("clamp_hi",  one,        8'd250, 0);
  endtask

  task automatic test_out_ready_idle();
    @(negedge clk); out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL ready_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [107:0] s1, s2, xs;
    logic [7:0]   xd;
    logic         xz, xe;
    int           lat, k;
    s1 = 108'd1 << 90;
    s2 = 108'd3 << 60;
    n_vec += 2;
    @(negedge clk);
    in_valid = 1'b1; in_sig = s1; in_est = 8'd70;
    @(posedge clk); #1;
    in_sig = s2; in_est = 8'd99;
    model(s1, 8'd70, xs, xd, xz, xe, lat);
    k = 1;
    while (out_valid !== 1'b1 && k < TMO) begin @(posedge clk); #1; k++; end
    if (k != lat) begin
      n_fail++; $display("FAIL bp_latency1: got %0d want %0d", k, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
      end
      check_result("bp_first", xs, xd, xz, xe);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_handshake: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_second_accept: got r=%b want 0", in_ready);
    end
    model(s2, 8'd99, xs, xd, xz, xe, lat);
    k = 1;
    while (out_valid !== 1'b1 && k < TMO) begin @(posedge clk); #1; k++; end
    if (k != lat) begin
      n_fail++; $display("FAIL bp_latency2: got %0d want %0d", k, lat);
    end
    check_result("bp_second", xs, xd, xz, xe);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_handshake2: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    n_vec++;
    @(negedge clk);
    in_valid = 1'b1; in_sig = 108'd1; in_est = 8'd160;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sig !== '0 || out_dist !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid: got v=%b r=%b sig=%h dist=%0d want v=0 r=1 sig=0 dist=0",
                         out_valid, in_ready, out_sig, out_dist);
    end
    @(negedge clk); reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_ghost: got v=%b want 0", out_valid);
      end
    end
    run_one("after_reset", 108'd1 << 100, 8'd60, 0);
  endtask

  task automatic test_random();
    logic [107:0] r;
    int           lz, est, mode;
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) r = '0;
      else r = 108'({$urandom, $urandom, $urandom, $urandom}) >> $urandom_range(0, 107);
      lz = 108;
      for (int b = 107; b >= 0; b--) begin
        if (r[b]) begin lz = 107 - b; break; end
      end
      if (mode < 7) est = 53 + lz - int'($urandom_range(0, 1));
      else          est = int'($urandom_range(0, 255));
      if (est < 0) est = 0;
      if (est > 255) est = 255;
      run_one("random", r, 8'(est), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_out_ready_idle();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
